adc_window_detector: RTL and testbench
======================================

# adc_window_detector

Downstream consumer of the 8-bit ADC sample stream, running in the `clk_25` domain. It splits the stream into fixed-length windows and, for each window, reports the peak sample, the peak's index, the window sum and a threshold-hit flag. Results leave through a single-entry valid/ready output register, so accumulation of the next window continues while the previous result waits.

## Interface
Parameters:
- `WIN_LEN`, 256: samples per window; power of two, 4..256.
- `CNT_W`, 8: log2(`WIN_LEN`); sizes the index counter.
- `THRESH`, 8'd128: hit threshold, unsigned.

Ports:
- `clk_25`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enADC`  in  1  capture enable; level-sensitive.
- `ad_data`  in  8  unsigned sample.
- `ad_valid`  in  1  sample strobe; a sample is accepted when `ad_valid & enADC` on a rising edge.
- `res_valid`  out  1  result register holds an unconsumed result.
- `res_ready`  in  1  consumer accepts; the transfer occurs when `res_valid & res_ready`.
- `res_peak`  out  8  maximum sample in the window.
- `res_peak_idx`  out  CNT_W  index (0-based) of the first occurrence of the maximum.
- `res_sum`  out  8+CNT_W  sum of all window samples.
- `res_hit`  out  1  `res_peak >= THRESH`.
- `overrun`  out  1  sticky; a completed window was dropped.

## Operation
- States: IDLE and ACCUM.
- IDLE:
  - Counter, running peak, peak index and sum are held at 0.
  - Moves to ACCUM on the first edge where `enADC` = 1.
- ACCUM: on each accepted sample at count `c`:
  - Running peak updates only on `ad_data > peak` (strict), so ties keep the earlier index.
  - The first sample of a window always loads peak = sample and idx = 0.
  - Sum adds the zero-extended sample; width 8+CNT_W never overflows.
  - Count increments and wraps to 0 after `WIN_LEN-1`.
- Window completion, on acceptance of sample `c = WIN_LEN-1`, using the final values including that sample:
  - If the output register is free, or is being drained in the same cycle (`res_valid & res_ready`), load the result and set `res_valid` = 1.
  - Otherwise keep the old result, discard the new one and set `overrun` = 1.
  - Accumulation restarts at count 0 on the next accepted sample; no samples are lost.
- `enADC` = 0 while in ACCUM aborts the window:
  - Discard partial state and return to IDLE.
  - The output register and `overrun` are unaffected.
- An output transfer without a simultaneous load clears `res_valid`; data outputs hold their last values.
- `overrun` is cleared only by `rst`.
- Reset mid-window: all state and outputs go to reset values immediately; no partial result is emitted.

## Timing
- Reset values: `res_valid` = 0, `res_peak` = 0, `res_peak_idx` = 0, `res_sum` = 0, `res_hit` = 0, `overrun` = 0; state = IDLE.
- Latency: the result is visible on outputs the cycle after the edge accepting the last sample, i.e. registered and 1 cycle.
- Throughput: one sample per clock; back-to-back windows are supported.
- `res_*` data outputs are stable while `res_valid` = 1 and not yet transferred.
- The first sample can be accepted on the same edge that leaves IDLE; `enADC` and `ad_valid` are sampled together.
- `ad_valid` while `enADC` = 0 is ignored.

## Configuration
- Macro: `ADC_WIN_SUM_EN`.
- Defined: the sum accumulator exists and `res_sum` reports the window sum.
- Undefined: the accumulator is not built and `res_sum` is tied to 0; the port remains, and all other behaviour is identical.

## Test plan
Bench uses `WIN_LEN` = 4, `CNT_W` = 2, `THRESH` = 128, `ADC_WIN_SUM_EN` defined unless stated.
- Samples 10, 200, 50, 200 with `res_ready` = 1 -> one cycle after the 4th: `res_valid` = 1, peak 200, idx 1, sum 460, hit 1.
- Samples 5, 5, 5, 5 -> peak 5, idx 0, sum 20, hit 0; `res_valid` drops the cycle after the `res_ready` transfer.
- Two back-to-back windows (1,2,3,4 then 9,8,7,6) with `res_ready` held 0 -> result stays 4/3/10; `overrun` = 1 after the 8th sample.
- Same two windows, with `res_ready` pulsed exactly on the 8th-sample completion edge -> second result 9/0/30 loaded, `res_valid` stays 1, `overrun` stays 0.
- `enADC` dropped after 2 samples (100, 150), then re-enabled with 1, 2, 3, 4 -> result 4/3/10, and 150 never reported.
- `rst` asserted mid-window with `res_valid` = 1 -> all outputs 0 asynchronously. With the macro undefined, rerun the first scenario -> `res_sum` = 0, other fields unchanged.

Source files
------------

// File: rtl/adc_window_detector.sv
// Splits the ADC sample stream into WIN_LEN-sample windows; reports peak, peak index, sum and threshold hit per window.
// Result held in a one-entry valid/ready register; sum accumulator built only with ADC_WIN_SUM_EN.
module adc_window_detector #(
  parameter int          WIN_LEN = 256,
  parameter int          CNT_W   = 8,
  parameter logic [7:0]  THRESH  = 8'd128
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic               enADC,
  input  logic [7:0]         ad_data,
  input  logic               ad_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [7:0]         res_peak,
  output logic [CNT_W-1:0]   res_peak_idx,
  output logic [8+CNT_W-1:0] res_sum,
  output logic               res_hit,
  output logic               overrun
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         peak_q, peak_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               res_valid_q, res_valid_d;
  logic [7:0]         res_peak_q, res_peak_d;
  logic [CNT_W-1:0]   res_idx_q, res_idx_d;
  logic               res_hit_q, res_hit_d;
  logic               overrun_q, overrun_d;

  logic               accept, clr_partial, first, win_done, load_res;
  logic [7:0]         peak_n;
  logic [CNT_W-1:0]   idx_n;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    peak_d      = peak_q;
    idx_d       = idx_q;
    res_valid_d = res_valid_q;
    res_peak_d  = res_peak_q;
    res_idx_d   = res_idx_q;
    res_hit_d   = res_hit_q;
    overrun_d   = overrun_q;
    accept      = 1'b0;
    clr_partial = 1'b0;
    load_res    = 1'b0;

    case (state_q)
      IDLE: begin
        clr_partial = 1'b1;
        if (enADC) begin
          state_d = ACCUM;
          accept  = ad_valid;
        end
      end
      ACCUM: begin
        if (!enADC) begin
          state_d     = IDLE;
          clr_partial = 1'b1;
        end else begin
          accept = ad_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    // First sample of a window always reloads; later samples only replace on strictly greater.
    first    = (cnt_q == '0);
    win_done = accept && (cnt_q == LAST_IDX);
    if (first || (ad_data > peak_q)) begin
      peak_n = ad_data;
      idx_n  = cnt_q;
    end else begin
      peak_n = peak_q;
      idx_n  = idx_q;
    end

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    if (clr_partial && !accept) begin
      cnt_d  = '0;
      peak_d = '0;
      idx_d  = '0;
    end else if (win_done) begin
      cnt_d  = '0;
      peak_d = '0;
      idx_d  = '0;
      if (!res_valid_q || res_ready) begin
        load_res    = 1'b1;
        res_valid_d = 1'b1;
        res_peak_d  = peak_n;
        res_idx_d   = idx_n;
        res_hit_d   = (peak_n >= THRESH);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      cnt_d  = cnt_q + CNT_W'(1);
      peak_d = peak_n;
      idx_d  = idx_n;
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      peak_q      <= '0;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_peak_q  <= '0;
      res_idx_q   <= '0;
      res_hit_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      peak_q      <= peak_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      res_peak_q  <= res_peak_d;
      res_idx_q   <= res_idx_d;
      res_hit_q   <= res_hit_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef ADC_WIN_SUM_EN
  localparam int SUM_W = 8 + CNT_W;

  logic [SUM_W-1:0] sum_q, sum_d, sum_n, res_sum_q, res_sum_d;

  always_comb begin
    sum_n     = first ? SUM_W'(ad_data) : (sum_q + SUM_W'(ad_data));
    sum_d     = sum_q;
    res_sum_d = res_sum_q;
    if ((clr_partial && !accept) || win_done) sum_d = '0;
    else if (accept)                          sum_d = sum_n;
    if (load_res) res_sum_d = sum_n;
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      res_sum_q <= '0;
    end else begin
      sum_q     <= sum_d;
      res_sum_q <= res_sum_d;
    end
  end

  assign res_sum = res_sum_q;
`else
  assign res_sum = '0;
`endif

  assign res_valid    = res_valid_q;
  assign res_peak     = res_peak_q;
  assign res_peak_idx = res_idx_q;
  assign res_hit      = res_hit_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_window_detector.sv
// Directed bench for adc_window_detector with WIN_LEN=4; sum expectations follow ADC_WIN_SUM_EN.
module tb_adc_window_detector;

  logic       clk_25 = 1'b0;
  logic       rst = 1'b0;
  logic       enADC = 1'b0;
  logic [7:0] ad_data = 8'd0;
  logic       ad_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       res_valid;
  logic [7:0] res_peak;
  logic [1:0] res_peak_idx;
  logic [9:0] res_sum;
  logic       res_hit;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  adc_window_detector #(.WIN_LEN(4), .CNT_W(2), .THRESH(8'd128)) dut (
    .clk_25(clk_25), .rst(rst), .enADC(enADC), .ad_data(ad_data), .ad_valid(ad_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_peak(res_peak),
    .res_peak_idx(res_peak_idx), .res_sum(res_sum), .res_hit(res_hit), .overrun(overrun)
  );

  always #20 clk_25 = ~clk_25;

  // {valid, peak, idx, sum, hit, overrun}
  wire [22:0] obs = {res_valid, res_peak, res_peak_idx, res_sum, res_hit, overrun};

  function automatic logic [9:0] xsum(input int v);
`ifdef ADC_WIN_SUM_EN
    return 10'(v);
`else
    return (v == 0) ? 10'd0 : 10'd0;
`endif
  endfunction

  function automatic logic [22:0] exp_vec(input logic v, input int pk, input int idx,
                                         input int sm, input logic hit, input logic ovr);
    return {v, 8'(pk), 2'(idx), xsum(sm), hit, ovr};
  endfunction

  task automatic send(input logic [7:0] d);
    ad_data  = d;
    ad_valid = 1'b1;
    @(posedge clk_25); #1;
    ad_valid = 1'b0;
  endtask

  task automatic drain;
    res_ready = 1'b1;
    @(posedge clk_25); #1;
    res_ready = 1'b0;
  endtask

  task automatic do_reset;
    #3 rst = 1'b1;
    #5 rst = 1'b0;
    @(posedge clk_25); #1;
  endtask

  task automatic test_reset;
    logic [22:0] e;
    do_reset();
    e = exp_vec(0, 0, 0, 0, 0, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_state got=%h exp=%h", obs, e); end
  endtask

  task automatic test_peak_tie;
    logic [22:0] e;
    enADC = 1'b1;
    res_ready = 1'b1;
    send(8'd10); send(8'd200); send(8'd50); send(8'd200);
    e = exp_vec(1, 200, 1, 460, 1, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL peak_tie got=%h exp=%h", obs, e); end
    @(posedge clk_25); #1;
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL peak_tie_drain got=%b exp=0", res_valid); end
  endtask

  task automatic test_flat_and_transfer;
    logic [22:0] e;
    send(8'd5); send(8'd5); send(8'd5); send(8'd5);
    e = exp_vec(1, 5, 0, 20, 0, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL flat_result got=%h exp=%h", obs, e); end
    @(posedge clk_25); #1;
    tests++;
    if (obs !== e) begin fails++; $display("FAIL flat_hold got=%h exp=%h", obs, e); end
    drain();
    e = exp_vec(0, 5, 0, 20, 0, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL flat_after_transfer got=%h exp=%h", obs, e); end
  endtask

  task automatic test_overrun;
    logic [22:0] e;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    e = exp_vec(1, 4, 3, 10, 0, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL ovr_first got=%h exp=%h", obs, e); end
    send(8'd9); send(8'd8); send(8'd7); send(8'd6);
    e = exp_vec(1, 4, 3, 10, 0, 1);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL ovr_second got=%h exp=%h", obs, e); end
    drain();
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_back_to_back;
    logic [22:0] e;
    do_reset();
    enADC = 1'b1;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    send(8'd9); send(8'd8); send(8'd7);
    res_ready = 1'b1;
    send(8'd6);
    res_ready = 1'b0;
    e = exp_vec(1, 9, 0, 30, 0, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL b2b_reload got=%h exp=%h", obs, e); end
    drain();
  endtask

  task automatic test_abort;
    logic [22:0] e;
    send(8'd100); send(8'd150);
    enADC = 1'b0;
    ad_valid = 1'b1;
    ad_data = 8'd250;
    @(posedge clk_25); #1;
    ad_valid = 1'b0;
    tests++;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL abort_no_result got=%b exp=0", res_valid); end
    enADC = 1'b1;
    send(8'd1); send(8'd2); send(8'd3);
    tests++;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL abort_early got=%b exp=0", res_valid); end
    send(8'd4);
    e = exp_vec(1, 4, 3, 10, 0, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL abort_restart got=%h exp=%h", obs, e); end
  endtask

  task automatic test_async_reset;
    logic [22:0] e;
    send(8'd77); send(8'd88);
    #5 rst = 1'b1;
    #1;
    e = exp_vec(0, 0, 0, 0, 0, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
    #3 rst = 1'b0;
    @(posedge clk_25); #1;
    send(8'd30); send(8'd40);
    tests++;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_no_partial got=%b exp=0", res_valid); end
    send(8'd20); send(8'd130);
    e = exp_vec(1, 130, 3, 220, 1, 0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL post_reset_window got=%h exp=%h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_peak_tie();
    test_flat_and_transfer();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
